register_file_2r1w: RTL and testbench
=====================================

Name: register_file_2r1w

Overview:
- 8-entry x 16-bit general-purpose register file for the pipelined processor.
- One write port, driven from write-back through the team's standard edge-triggered register convention.
- Two read ports feeding the decode/execute boundary. It is the reader side of the architectural registers.
- Read data is registered: 1-cycle latency, with same-cycle write-through bypass and a stall hold.

Parameters:
- WIDTH, 16, data width of each register and port.
- DEPTH, 8, number of registers; must be a power of two.
- AW, 3, address width = log2(DEPTH).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high; clears all registers and outputs.
- WR_EN  in  1  write enable.
- WR_ADDR  in  AW  write register index.
- WR_DATA  in  WIDTH  write data.
- RD_EN  in  1  read enable; low = hold outputs (pipeline stall).
- RA_ADDR  in  AW  read port A index.
- RB_ADDR  in  AW  read port B index.
- RA_DATA  out  WIDTH  registered read data, port A.
- RB_DATA  out  WIDTH  registered read data, port B.

Behaviour:
- RST high, any time including mid-operation: all DEPTH entries, RA_DATA and RB_DATA become 0 immediately. Writes and reads are ignored while RST is high.
- Write: rising CLK with WR_EN=1 and RST=0 sets entry[WR_ADDR] <= WR_DATA. WR_EN=0 leaves the entry unchanged.
- Read: rising CLK with RD_EN=1 sets RA_DATA <= value(RA_ADDR) and RB_DATA <= value(RB_ADDR). Latency is exactly 1 cycle from address to data.
- Bypass: value(x) = WR_DATA if WR_EN=1 and WR_ADDR==x, otherwise entry[x]. A write and a read of the same index in the same cycle therefore return the new data next cycle, with no stale read.
- RA_ADDR==RB_ADDR: both ports return the same value, bypass included.
- RD_EN=0: RA_DATA and RB_DATA hold their previous values. Writes still proceed. A held output is not refreshed by a later write to its index.
- Addresses are always in range, since DEPTH = 2^AW; no bounds logic is needed.
- No X propagation after reset: every bit has a defined value.

Optional Feature:
- Macro REGFILE_ZERO_REG_EN.
- Defined: entry 0 is hardwired to 0. Writes to index 0 are discarded, and reads of index 0 return 0 even when bypassing a same-cycle write to 0.
- Undefined: entry 0 is an ordinary register.

Decomposition:
- Shared processor package holds:
  - WIDTH constant (16).
  - Register-count constant (8) and AW constant (3).
  - Register-index typedef (logic [2:0]).
  - Data-word typedef (logic [15:0]).
- One sub-module is natural: regfile_read_port (address in, bypass compare, output register with RD_EN hold).
  - Instantiate it twice; the storage array and write logic live in the top level.

Test Plan:
- Reset: preload entries, assert RST mid-cycle -> RA_DATA=RB_DATA=0 immediately. After release, reading every index returns 0x0000.
- Write/read: write 0xBEEF to r3, then read RA=r3, RB=r5 (5 previously written 0x1234) with RD_EN=1 -> RA_DATA=0xBEEF, RB_DATA=0x1234 one cycle later.
- Bypass: same cycle WR_EN=1, WR_ADDR=2, WR_DATA=0xA5A5 and RA_ADDR=RB_ADDR=2 (old 0x0001) -> both outputs 0xA5A5 next cycle.
- Stall: RA_DATA=0x1111 from r1; set RD_EN=0, write 0x2222 to r1 -> RA_DATA stays 0x1111. Raise RD_EN -> RA_DATA=0x2222 next cycle.
- WR_EN=0: present WR_ADDR=4, WR_DATA=0xFFFF with WR_EN=0 -> reading r4 returns its prior value 0x0042.
- REGFILE_ZERO_REG_EN defined: write 0x7777 to r0 with simultaneous read of r0 -> 0x0000 that cycle and every later one. Without the macro -> 0x7777.

Source files
------------

// File: rtl/register_file_2r1w_pkg.sv
// Shared processor constants and types for the 2-read/1-write register file.
package register_file_2r1w_pkg;
  localparam int RF_WIDTH = 16;
  localparam int RF_DEPTH = 8;
  localparam int RF_AW    = 3;

  typedef logic [RF_AW-1:0]    reg_idx_t;
  typedef logic [RF_WIDTH-1:0] data_word_t;
endpackage

// File: rtl/register_file_2r1w_read_port.sv
// One registered read port: same-cycle write bypass and RD_EN stall hold.
// With REGFILE_ZERO_REG_EN defined, index 0 always reads as zero.
module regfile_read_port
  import register_file_2r1w_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH,
  parameter int AW    = RF_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [AW-1:0]    addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] regs [DEPTH],
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] value_s;

  // Select the architectural value, forwarding a write to the same index.
  always_comb begin
    value_s = regs[addr];
    if (wr_en && (wr_addr == addr)) begin
      value_s = wr_data;
    end else begin
      value_s = regs[addr];
    end
`ifdef REGFILE_ZERO_REG_EN
    if (addr == {AW{1'b0}}) begin
      value_s = {WIDTH{1'b0}};
    end else begin
      value_s = value_s;
    end
`endif
  end

  // Output register; holds its value while the pipeline is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= {WIDTH{1'b0}};
    end else if (rd_en) begin
      data <= value_s;
    end else begin
      data <= data;
    end
  end

endmodule

// File: rtl/register_file_2r1w.sv
// 8x16 register file, one write port and two registered read ports with bypass.
// Optional: REGFILE_ZERO_REG_EN makes entry 0 a hardwired zero register.
module register_file_2r1w
  import register_file_2r1w_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH,
  parameter int AW    = RF_AW
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WR_EN,
  input  logic [AW-1:0]    WR_ADDR,
  input  logic [WIDTH-1:0] WR_DATA,
  input  logic             RD_EN,
  input  logic [AW-1:0]    RA_ADDR,
  input  logic [AW-1:0]    RB_ADDR,
  output logic [WIDTH-1:0] RA_DATA,
  output logic [WIDTH-1:0] RB_DATA
);

  logic [WIDTH-1:0] regs_r [DEPTH];
  logic             wr_act_s;

  // Qualify the write strobe; index 0 is read-only when it is the zero register.
  always_comb begin
    wr_act_s = WR_EN;
`ifdef REGFILE_ZERO_REG_EN
    if (WR_ADDR == {AW{1'b0}}) begin
      wr_act_s = 1'b0;
    end else begin
      wr_act_s = WR_EN;
    end
`endif
  end

  // Storage array: cleared asynchronously, written on the rising edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_act_s) begin
      regs_r[WR_ADDR] <= WR_DATA;
    end else begin
      regs_r <= regs_r;
    end
  end

  regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_port_a (
    .clk     (CLK),
    .rst     (RST),
    .rd_en   (RD_EN),
    .addr    (RA_ADDR),
    .wr_en   (WR_EN),
    .wr_addr (WR_ADDR),
    .wr_data (WR_DATA),
    .regs    (regs_r),
    .data    (RA_DATA)
  );

  regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_port_b (
    .clk     (CLK),
    .rst     (RST),
    .rd_en   (RD_EN),
    .addr    (RB_ADDR),
    .wr_en   (WR_EN),
    .wr_addr (WR_ADDR),
    .wr_data (WR_DATA),
    .regs    (regs_r),
    .data    (RB_DATA)
  );

endmodule

// File: tb/tb_register_file_2r1w.sv
// Scoreboard bench for register_file_2r1w: driver queues expected outputs, monitor compares.
module tb_register_file_2r1w;
  import register_file_2r1w_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       WR_EN = 1'b0;
  reg_idx_t   WR_ADDR = 3'd0;
  data_word_t WR_DATA = 16'h0000;
  logic       RD_EN = 1'b0;
  reg_idx_t   RA_ADDR = 3'd0;
  reg_idx_t   RB_ADDR = 3'd0;
  data_word_t RA_DATA;
  data_word_t RB_DATA;

  typedef struct {
    data_word_t ea;
    data_word_t eb;
    string      name;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

`ifdef REGFILE_ZERO_REG_EN
  localparam data_word_t ZEXP = 16'h0000;
`else
  localparam data_word_t ZEXP = 16'h7777;
`endif

  register_file_2r1w dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .RD_EN(RD_EN), .RA_ADDR(RA_ADDR), .RB_ADDR(RB_ADDR),
    .RA_DATA(RA_DATA), .RB_DATA(RB_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input data_word_t act, input data_word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after its rising edge.
  task automatic cyc(input logic we, input reg_idx_t wa, input data_word_t wd,
                     input logic re, input reg_idx_t ra, input reg_idx_t rb,
                     input data_word_t ea, input data_word_t eb, input string name);
    exp_t e;
    @(negedge CLK);
    WR_EN = we; WR_ADDR = wa; WR_DATA = wd;
    RD_EN = re; RA_ADDR = ra; RB_ADDR = rb;
    e.ea = ea; e.eb = eb; e.name = name;
    q.push_back(e);
    @(posedge CLK);
  endtask

  // Monitor: compare queued expectations shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.name, "_a"}, RA_DATA, e.ea);
        chk({e.name, "_b"}, RB_DATA, e.eb);
      end
    end
  end

  initial begin
    int wait_cyc;
    #2;
    chk("reset_ra", RA_DATA, 16'h0000);
    chk("reset_rb", RB_DATA, 16'h0000);
    @(negedge CLK);
    RST = 1'b0;

    // Preload, then read back before a mid-operation reset.
    cyc(1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, "pre_w5");
    cyc(1'b1, 3'd7, 16'h9999, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, "pre_w7");
    cyc(1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd7, 16'h1234, 16'h9999, "pre_rd");

    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("midrst_ra", RA_DATA, 16'h0000);
    chk("midrst_rb", RB_DATA, 16'h0000);
    WR_EN = 1'b1; WR_ADDR = 3'd6; WR_DATA = 16'hABCD; RD_EN = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0; WR_EN = 1'b0;

    cyc(1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd1, 16'h0000, 16'h0000, "clr01");
    cyc(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd3, 16'h0000, 16'h0000, "clr23");
    cyc(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 3'd5, 16'h0000, 16'h0000, "clr45");
    cyc(1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 3'd7, 16'h0000, 16'h0000, "clr67");

    // Write/read.
    cyc(1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, "w5");
    cyc(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, "w3");
    cyc(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd5, 16'hBEEF, 16'h1234, "rd35");

    // Bypass on both ports reading the index being written.
    cyc(1'b1, 3'd2, 16'h0001, 1'b1, 3'd3, 3'd5, 16'hBEEF, 16'h1234, "w2old");
    cyc(1'b1, 3'd2, 16'hA5A5, 1'b1, 3'd2, 3'd2, 16'hA5A5, 16'hA5A5, "bypass");
    cyc(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd3, 16'hA5A5, 16'hBEEF, "rd23");

    // Stall hold: a later write must not refresh the held output.
    cyc(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 3'd3, 16'hA5A5, 16'hBEEF, "w1");
    cyc(1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 3'd2, 16'h1111, 16'hA5A5, "rd1");
    cyc(1'b1, 3'd1, 16'h2222, 1'b0, 3'd1, 3'd1, 16'h1111, 16'hA5A5, "stall_w");
    cyc(1'b0, 3'd0, 16'h0000, 1'b0, 3'd1, 3'd1, 16'h1111, 16'hA5A5, "stall");
    cyc(1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 3'd1, 16'h2222, 16'h2222, "unstall");

    // WR_EN low: neither storage nor bypass affected.
    cyc(1'b1, 3'd4, 16'h0042, 1'b1, 3'd1, 3'd1, 16'h2222, 16'h2222, "w4");
    cyc(1'b0, 3'd4, 16'hFFFF, 1'b1, 3'd4, 3'd4, 16'h0042, 16'h0042, "noen_byp");
    cyc(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 3'd5, 16'h0042, 16'h1234, "noen_rd");

    // Register 0 (zero register when the macro is defined); r6 write during reset ignored.
    cyc(1'b1, 3'd0, 16'h7777, 1'b1, 3'd0, 3'd6, ZEXP, 16'h0000, "r0_byp");
    cyc(1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd0, ZEXP, ZEXP, "r0_rd");

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 20) begin
      @(posedge CLK);
      wait_cyc++;
    end
    #2;
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
